acp_write_arbiter: RTL and testbench



---
 rtl/acp_arb_pkg.sv | 26 ++
 rtl/acp_write_arbiter_rr_arbiter.sv | 34 +++
 rtl/acp_write_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_acp_write_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acp_arb_pkg.sv
// Shared definitions for the ACP write arbiter: FSM encodings, AXI constants
// and the 4KB burst-boundary helper.
package acp_arb_pkg;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 3'd0;
  localparam arb_state_t ST_CHECK = 3'd1;
  localparam arb_state_t ST_ADDR  = 3'd2;
  localparam arb_state_t ST_DATA  = 3'd3;
  localparam arb_state_t ST_RESP  = 3'd4;

  localparam logic [2:0] AXI_SIZE_64    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // A 64-bit INCR burst stays inside its 4KB page only if the last
  // doubleword index (start index + len) still fits in 9 bits.
  function automatic logic crosses_4kb(input logic [8:0] addr_dw,
                                       input logic [7:0] len);
    logic [9:0] last_dw;
    last_dw = {1'b0, addr_dw} + {2'b00, len};
    return (last_dw > 10'd511);
  endfunction

endpackage

// File: rtl/acp_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: returns the first active request at or
// after the pointer, wrapping modulo NUM_REQ, as one-hot grant and index.
module rr_arbiter
  import acp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  // Scan from the pointer position so the most recently served requester is last.
  always_comb begin
    int   slot;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    slot  = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      slot = int'(ptr) + off;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      if (!found && req[slot]) begin
        found       = 1'b1;
        grant[slot] = 1'b1;
        idx         = slot[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/acp_write_arbiter.sv
// Shares the 64-bit ACP AXI3 write path between NUM_REQ accelerators: one
// coherent burst at a time, round-robin granted, with 4KB/length screening.
module acp_write_arbiter
  import acp_arb_pkg::*;
#(
  parameter int         NUM_REQ     = 4,
  parameter logic [3:0] AWCACHE_VAL = 4'b1111,
  parameter logic [4:0] AWUSER_VAL  = 5'b00001,
  parameter logic [2:0] AWPROT_VAL  = 3'b000,
  parameter int         MAX_LEN     = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_addr,
  input  logic [NUM_REQ*8-1:0]    req_len,
  input  logic [NUM_REQ*64-1:0]   wr_data,
  input  logic [NUM_REQ*8-1:0]    wr_strb,
  input  logic [NUM_REQ-1:0]      wr_valid,
  output logic [NUM_REQ-1:0]      wr_ready,
  output logic [NUM_REQ-1:0]      done,
  output logic [NUM_REQ-1:0]      err,
  output logic                    busy,
  output logic [2:0]              grant_id,
  output logic [31:0]             M_AXI_AWADDR,
  output logic [7:0]              M_AXI_AWLEN,
  output logic [2:0]              M_AXI_AWSIZE,
  output logic [1:0]              M_AXI_AWBURST,
  output logic [3:0]              M_AXI_AWCACHE,
  output logic [4:0]              M_AXI_AWUSER,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [63:0]             M_AXI_WDATA,
  output logic [7:0]              M_AXI_WSTRB,
  output logic                    M_AXI_WLAST,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0][31:0] addr_arr;
  logic [NUM_REQ-1:0][7:0]  len_arr;
  logic [NUM_REQ-1:0][63:0] data_arr;
  logic [NUM_REQ-1:0][7:0]  strb_arr;

  assign addr_arr = req_addr;
  assign len_arr  = req_len;
  assign data_arr = wr_data;
  assign strb_arr = wr_strb;

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_q;
  logic [31:0]        lat_addr;
  logic [7:0]         lat_len;
  logic [7:0]         beat_cnt;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               any_req;
  logic               reject;
  logic               last_beat;
  logic               w_hs;
  logic [IDX_W-1:0]   next_ptr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign any_req   = |arb_grant;
  assign reject    = (lat_len > 8'(MAX_LEN)) || crosses_4kb(lat_addr[11:3], lat_len);
  assign last_beat = (beat_cnt == lat_len);
  assign w_hs      = (state == ST_DATA) && wr_valid[grant_q] && M_AXI_WREADY;
  assign next_ptr  = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
  assign busy      = (state != ST_IDLE);
  assign grant_id  = 3'(grant_q);

  // Burst sequencing: latch a winner, screen it, then walk AW, W and B in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant_q  <= '0;
      lat_addr <= '0;
      lat_len  <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_q  <= arb_idx;
            lat_addr <= addr_arr[arb_idx];
            lat_len  <= len_arr[arb_idx];
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (reject) begin
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end else begin
            state  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (M_AXI_AWREADY) begin
            beat_cnt <= '0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (M_AXI_BVALID) begin
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Channel outputs are decoded from the state so everything drops at once on reset.
  always_comb begin
    req_ready     = '0;
    wr_ready      = '0;
    done          = '0;
    err           = '0;
    M_AXI_AWADDR  = '0;
    M_AXI_AWLEN   = '0;
    M_AXI_AWSIZE  = '0;
    M_AXI_AWBURST = '0;
    M_AXI_AWCACHE = '0;
    M_AXI_AWUSER  = '0;
    M_AXI_AWPROT  = '0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WDATA   = '0;
    M_AXI_WSTRB   = '0;
    M_AXI_WLAST   = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    case (state)
      ST_CHECK: begin
        if (reject) begin
          req_ready[grant_q] = 1'b1;
          done[grant_q]      = 1'b1;
          err[grant_q]       = 1'b1;
        end
      end
      ST_ADDR: begin
        M_AXI_AWVALID      = 1'b1;
        M_AXI_AWADDR       = lat_addr & 32'hFFFF_FFF8;
        M_AXI_AWLEN        = lat_len;
        M_AXI_AWSIZE       = AXI_SIZE_64;
        M_AXI_AWBURST      = AXI_BURST_INCR;
        M_AXI_AWCACHE      = AWCACHE_VAL;
        M_AXI_AWUSER       = AWUSER_VAL;
        M_AXI_AWPROT       = AWPROT_VAL;
        req_ready[grant_q] = M_AXI_AWREADY;
      end
      ST_DATA: begin
        M_AXI_WDATA       = data_arr[grant_q];
        M_AXI_WSTRB       = strb_arr[grant_q];
        M_AXI_WVALID      = wr_valid[grant_q];
        M_AXI_WLAST       = last_beat;
        wr_ready[grant_q] = M_AXI_WREADY;
      end
      ST_RESP: begin
        M_AXI_BREADY  = 1'b1;
        done[grant_q] = M_AXI_BVALID;
        err[grant_q]  = M_AXI_BVALID && (M_AXI_BRESP != AXI_RESP_OKAY);
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_acp_write_arbiter.sv
// Directed bench for acp_write_arbiter: single burst, round-robin order,
// backpressure, rejection, error response and reset mid-burst.
module tb_acp_write_arbiter;

  localparam int NUM_REQ = 4;

  logic clk;
  logic rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][31:0] addr_v;
  logic [NUM_REQ-1:0][7:0]  len_v;
  logic [NUM_REQ-1:0][63:0] data_v;
  logic [NUM_REQ-1:0][7:0]  strb_v;
  logic [NUM_REQ*32-1:0]    req_addr;
  logic [NUM_REQ*8-1:0]     req_len;
  logic [NUM_REQ*64-1:0]    wr_data;
  logic [NUM_REQ*8-1:0]     wr_strb;
  logic [NUM_REQ-1:0]       wr_valid;
  logic [NUM_REQ-1:0]       wr_ready;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ-1:0]       err;
  logic                     busy;
  logic [2:0]               grant_id;
  logic [31:0] M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic [3:0]  M_AXI_AWCACHE;
  logic [4:0]  M_AXI_AWUSER;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [63:0] M_AXI_WDATA;
  logic [7:0]  M_AXI_WSTRB;
  logic        M_AXI_WLAST;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;

  int tests_run;
  int tests_failed;

  assign req_addr = addr_v;
  assign req_len  = len_v;
  assign wr_data  = data_v;
  assign wr_strb  = strb_v;

  acp_write_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .done          (done),
    .err           (err),
    .busy          (busy),
    .grant_id      (grant_id),
    .M_AXI_AWADDR  (M_AXI_AWADDR),
    .M_AXI_AWLEN   (M_AXI_AWLEN),
    .M_AXI_AWSIZE  (M_AXI_AWSIZE),
    .M_AXI_AWBURST (M_AXI_AWBURST),
    .M_AXI_AWCACHE (M_AXI_AWCACHE),
    .M_AXI_AWUSER  (M_AXI_AWUSER),
    .M_AXI_AWPROT  (M_AXI_AWPROT),
    .M_AXI_AWVALID (M_AXI_AWVALID),
    .M_AXI_AWREADY (M_AXI_AWREADY),
    .M_AXI_WDATA   (M_AXI_WDATA),
    .M_AXI_WSTRB   (M_AXI_WSTRB),
    .M_AXI_WLAST   (M_AXI_WLAST),
    .M_AXI_WVALID  (M_AXI_WVALID),
    .M_AXI_WREADY  (M_AXI_WREADY),
    .M_AXI_BRESP   (M_AXI_BRESP),
    .M_AXI_BVALID  (M_AXI_BVALID),
    .M_AXI_BREADY  (M_AXI_BREADY)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Last-resort guard so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        tests_failed++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  int   rr_exp [5] = '{0, 1, 2, 3, 0};
  logic wready_pat [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic wlast_pat  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  // Linear sequence of directed scenarios.
  initial begin
    int wait_cnt;
    int beats;
    tests_run     = 0;
    tests_failed  = 0;
    rst_n         = 1'b0;
    req_valid     = '0;
    addr_v        = '0;
    len_v         = '0;
    data_v        = '0;
    strb_v        = '0;
    wr_valid      = '0;
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    M_AXI_BRESP   = 2'b00;
    M_AXI_BVALID  = 1'b0;
    #2;
    checkOutput("reset_busy",     64'(busy),          64'h0);
    checkOutput("reset_awvalid",  64'(M_AXI_AWVALID), 64'h0);
    checkOutput("reset_awaddr",   64'(M_AXI_AWADDR),  64'h0);
    checkOutput("reset_awlen",    64'(M_AXI_AWLEN),   64'h0);
    checkOutput("reset_done",     64'(done),          64'h0);
    checkOutput("reset_grant",    64'(grant_id),      64'h0);
    step();
    rst_n = 1'b1;
    step();

    // Single request from requester 0, len 3, no backpressure.
    addr_v[0]     = 32'h1000_0000;
    len_v[0]      = 8'd3;
    data_v[0]     = 64'hDEAD_BEEF_0123_4567;
    strb_v[0]     = 8'hFF;
    req_valid[0]  = 1'b1;
    wr_valid[0]   = 1'b1;
    M_AXI_AWREADY = 1'b1;
    M_AXI_WREADY  = 1'b1;
    #1;
    checkOutput("single_aw_c0", 64'(M_AXI_AWVALID), 64'h0);
    step();
    checkOutput("single_busy_check", 64'(busy), 64'h1);
    checkOutput("single_aw_c1", 64'(M_AXI_AWVALID), 64'h0);
    step();
    checkOutput("single_aw_c2",   64'(M_AXI_AWVALID), 64'h1);
    checkOutput("single_awaddr",  64'(M_AXI_AWADDR),  64'h1000_0000);
    checkOutput("single_awlen",   64'(M_AXI_AWLEN),   64'h3);
    checkOutput("single_awcache", 64'(M_AXI_AWCACHE), 64'hF);
    checkOutput("single_awuser",  64'(M_AXI_AWUSER),  64'h01);
    checkOutput("single_awsize",  64'(M_AXI_AWSIZE),  64'h3);
    checkOutput("single_awburst", 64'(M_AXI_AWBURST), 64'h1);
    checkOutput("single_ready",   64'(req_ready),     64'b0001);
    checkOutput("single_no_w",    64'(M_AXI_WVALID),  64'h0);
    req_valid[0] = 1'b0;
    step();
    checkOutput("single_wdata",   M_AXI_WDATA,        64'hDEAD_BEEF_0123_4567);
    checkOutput("single_wready",  64'(wr_ready),      64'b0001);
    for (int b = 0; b < 4; b++) begin
      checkOutput($sformatf("single_wlast_b%0d", b), 64'(M_AXI_WLAST), (b == 3) ? 64'h1 : 64'h0);
      step();
    end
    checkOutput("single_bready", 64'(M_AXI_BREADY), 64'h1);
    checkOutput("single_done_wait", 64'(done), 64'h0);
    M_AXI_BVALID = 1'b1;
    M_AXI_BRESP  = 2'b00;
    #1;
    checkOutput("single_done", 64'(done), 64'b0001);
    checkOutput("single_err",  64'(err),  64'b0000);
    step();
    M_AXI_BVALID = 1'b0;
    #1;
    checkOutput("single_idle", 64'(busy), 64'h0);

    // Reset to bring the pointer back to 0, then round-robin with all requesting.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_v[i] = 32'h0000_1000 * (i + 1);
      len_v[i]  = 8'd0;
      data_v[i] = 64'(i + 16);
      strb_v[i] = 8'hFF;
    end
    req_valid    = 4'b1111;
    wr_valid     = 4'b1111;
    M_AXI_BVALID = 1'b1;
    M_AXI_BRESP  = 2'b00;
    #1;
    for (int k = 0; k < 5; k++) begin
      wait_cnt = 0;
      while (M_AXI_AWVALID !== 1'b1 && wait_cnt < 20) begin
        step();
        #1;
        wait_cnt++;
      end
      checkOutput($sformatf("rr_awvalid_%0d", k), 64'(M_AXI_AWVALID), 64'h1);
      checkOutput($sformatf("rr_grant_%0d", k),   64'(grant_id), 64'(rr_exp[k]));
      checkOutput($sformatf("rr_awaddr_%0d", k),  64'(M_AXI_AWADDR),
                  64'(32'h0000_1000 * (rr_exp[k] + 1)));
      step();
      #1;
    end
    req_valid = '0;
    step();
    step();
    M_AXI_BVALID = 1'b0;
    #1;
    checkOutput("rr_drained", 64'(busy), 64'h0);

    // Backpressure: requester 2, AWREADY late, WREADY toggling.
    addr_v[2]     = 32'h2000_0040;
    len_v[2]      = 8'd3;
    data_v[2]     = 64'h2222_3333_4444_5555;
    strb_v[2]     = 8'h0F;
    wr_valid      = 4'b0100;
    req_valid[2]  = 1'b1;
    M_AXI_AWREADY = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_awvalid_%0d", i), 64'(M_AXI_AWVALID), 64'h1);
      checkOutput($sformatf("bp_awaddr_%0d", i),  64'(M_AXI_AWADDR),  64'h2000_0040);
      checkOutput($sformatf("bp_noready_%0d", i), 64'(req_ready),     64'h0);
      step();
    end
    checkOutput("bp_grant", 64'(grant_id), 64'h2);
    M_AXI_AWREADY = 1'b1;
    #1;
    checkOutput("bp_ready", 64'(req_ready), 64'b0100);
    step();
    M_AXI_AWREADY = 1'b0;
    req_valid     = '0;
    beats         = 0;
    for (int c = 0; c < 7; c++) begin
      M_AXI_WREADY = wready_pat[c];
      #1;
      checkOutput($sformatf("bp_wready_%0d", c), 64'(wr_ready), wready_pat[c] ? 64'b0100 : 64'h0);
      checkOutput($sformatf("bp_wlast_%0d", c),  64'(M_AXI_WLAST), 64'(wlast_pat[c]));
      if (M_AXI_WVALID && M_AXI_WREADY) beats++;
      step();
    end
    M_AXI_WREADY = 1'b1;
    #1;
    checkOutput("bp_beats",   64'(beats), 64'd4);
    checkOutput("bp_wstop",   64'(M_AXI_WVALID), 64'h0);
    checkOutput("bp_bready",  64'(M_AXI_BREADY), 64'h1);
    M_AXI_BVALID = 1'b1;
    #1;
    checkOutput("bp_done", 64'(done), 64'b0100);
    step();
    M_AXI_BVALID = 1'b0;

    // Rejections: over-long burst, then a 4KB crossing.
    addr_v[2]    = 32'h3000_0000;
    len_v[2]     = 8'd16;
    req_valid[2] = 1'b1;
    step();
    checkOutput("rej_len_ready", 64'(req_ready),     64'b0100);
    checkOutput("rej_len_done",  64'(done),          64'b0100);
    checkOutput("rej_len_err",   64'(err),           64'b0100);
    checkOutput("rej_len_aw",    64'(M_AXI_AWVALID), 64'h0);
    req_valid[2] = 1'b0;
    step();
    checkOutput("rej_len_idle", 64'(busy), 64'h0);
    addr_v[1]    = 32'h0000_0FF8;
    len_v[1]     = 8'd1;
    req_valid[1] = 1'b1;
    step();
    checkOutput("rej_4k_ready", 64'(req_ready),     64'b0010);
    checkOutput("rej_4k_done",  64'(done),          64'b0010);
    checkOutput("rej_4k_err",   64'(err),           64'b0010);
    checkOutput("rej_4k_aw",    64'(M_AXI_AWVALID), 64'h0);
    req_valid[1] = 1'b0;
    step();
    checkOutput("rej_4k_aw_after", 64'(M_AXI_AWVALID), 64'h0);

    // Error response on requester 3, then a normal arbitration from pointer 0.
    addr_v[3]     = 32'h4000_0000;
    len_v[3]      = 8'd0;
    wr_valid      = 4'b1010;
    req_valid[3]  = 1'b1;
    M_AXI_AWREADY = 1'b1;
    step();
    step();
    checkOutput("errb_ready", 64'(req_ready), 64'b1000);
    req_valid[3] = 1'b0;
    step();
    checkOutput("errb_wlast", 64'(M_AXI_WLAST), 64'h1);
    step();
    M_AXI_BVALID = 1'b1;
    M_AXI_BRESP  = 2'b10;
    #1;
    checkOutput("errb_done", 64'(done), 64'b1000);
    checkOutput("errb_err",  64'(err),  64'b1000);
    step();
    M_AXI_BVALID = 1'b0;
    M_AXI_BRESP  = 2'b00;
    addr_v[1]    = 32'h0000_2000;
    len_v[1]     = 8'd0;
    req_valid    = 4'b1010;
    step();
    checkOutput("after_err_grant", 64'(grant_id), 64'h1);
    checkOutput("after_err_clear", 64'(err),      64'h0);
    step();
    checkOutput("after_err_ready", 64'(req_ready), 64'b0010);
    req_valid = '0;
    step();
    step();
    M_AXI_BVALID = 1'b1;
    #1;
    checkOutput("after_err_done", 64'(done), 64'b0010);
    checkOutput("after_err_err",  64'(err),  64'h0);
    step();
    M_AXI_BVALID = 1'b0;

    // Reset two beats into an eight-beat burst from requester 2.
    addr_v[2]    = 32'h5000_0000;
    len_v[2]     = 8'd7;
    wr_valid     = 4'b0100;
    req_valid[2] = 1'b1;
    step();
    step();
    req_valid = '0;
    step();
    step();
    step();
    checkOutput("rst_mid_active", 64'(M_AXI_WVALID), 64'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_wvalid",  64'(M_AXI_WVALID),  64'h0);
    checkOutput("rst_mid_wready",  64'(wr_ready),      64'h0);
    checkOutput("rst_mid_awvalid", 64'(M_AXI_AWVALID), 64'h0);
    checkOutput("rst_mid_busy",    64'(busy),          64'h0);
    checkOutput("rst_mid_grant",   64'(grant_id),      64'h0);
    step();
    rst_n     = 1'b1;
    addr_v[0] = 32'h6000_0008;
    len_v[0]  = 8'd0;
    wr_valid  = 4'b0101;
    req_valid = 4'b0101;
    step();
    checkOutput("post_rst_grant", 64'(grant_id), 64'h0);
    step();
    checkOutput("post_rst_awaddr", 64'(M_AXI_AWADDR), 64'h6000_0008);
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
